// File: rtl/sort_pkg.sv
// Shared types and constants for the 4x8-bit sorter front end.
package sort_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned FRAME_W = LANES * W;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned IDX_W   = $clog2(LANES);
  localparam int unsigned FILL_W  = $clog2(LANES + 1);
  localparam int unsigned LEN_W   = 3;

  typedef logic [W-1:0]      lane_t;
  typedef lane_t [LANES-1:0] frame_t;

endpackage

// File: rtl/sort_4x8b_frame_packer.sv
// Packs a byte stream into 4-byte frames behind a one-frame assembly stage and an output
// holding register. Optional short-frame support is enabled with `SORT_PACK_LAST_EN.
module sort_4x8b_frame_packer
  import sort_pkg::*;
#(
  parameter logic [W-1:0] PAD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef SORT_PACK_LAST_EN
  input  logic               in_last,
  output logic [LEN_W-1:0]   frame_len,
`endif
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [CNT_W-1:0]   frame_count
);

  frame_t             asm_q, asm_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FILL_W-1:0]  cnt_q, cnt_d;
  frame_t             frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
`ifdef SORT_PACK_LAST_EN
  logic [LEN_W-1:0]   alen_q, alen_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
`endif

  logic in_fire, out_fire, out_free, asm_full, done;

  assign in_ready = (cnt_q != FILL_W'(LANES));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = frame_valid_q & frame_ready;
  assign out_free = ~frame_valid_q | frame_ready;

  always_comb begin
    asm_d         = asm_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    frame_count_d = frame_count_q;
    done          = 1'b0;
`ifdef SORT_PACK_LAST_EN
    alen_d        = alen_q;
    frame_len_d   = frame_len_q;
`endif

    if (in_fire) begin
      asm_d[idx_q] = in_data;
      done         = (idx_q == IDX_W'(LANES - 1));
`ifdef SORT_PACK_LAST_EN
      alen_d = LEN_W'(idx_q) + LEN_W'(1);
      if (in_last) begin
        done = 1'b1;
        for (int unsigned l = 0; l < LANES; l++) begin
          if (IDX_W'(l) > idx_q) asm_d[l] = PAD;
        end
      end
`endif
    end

    asm_full = (cnt_q == FILL_W'(LANES)) | done;

    if (out_fire) frame_valid_d = 1'b0;

    // A completed frame moves out whenever the holding register is free or draining now.
    if (asm_full && out_free) begin
      frame_data_d  = asm_d;
      frame_valid_d = 1'b1;
      idx_d         = '0;
      cnt_d         = '0;
      frame_count_d = frame_count_q + CNT_W'(1);
`ifdef SORT_PACK_LAST_EN
      frame_len_d   = alen_d;
`endif
    end else if (done) begin
      cnt_d = FILL_W'(LANES);
    end else if (in_fire) begin
      idx_d = idx_q + IDX_W'(1);
      cnt_d = cnt_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q         <= {LANES{PAD}};
      idx_q         <= '0;
      cnt_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
`ifdef SORT_PACK_LAST_EN
      alen_q        <= '0;
      frame_len_q   <= '0;
`endif
    end else begin
      asm_q         <= asm_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
`ifdef SORT_PACK_LAST_EN
      alen_q        <= alen_d;
      frame_len_q   <= frame_len_d;
`endif
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
`ifdef SORT_PACK_LAST_EN
  assign frame_len   = frame_len_q;
`endif

endmodule

// File: tb/tb_sort_4x8b_frame_packer.sv
// Directed, table-driven bench for sort_4x8b_frame_packer (covers `SORT_PACK_LAST_EN when set).
module tb_sort_4x8b_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_count;
`ifdef SORT_PACK_LAST_EN
  logic [2:0]  frame_len;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sort_4x8b_frame_packer #(
    .PAD(8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef SORT_PACK_LAST_EN
    .in_last    (in_last),
    .frame_len  (frame_len),
`endif
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_count(frame_count)
  );

  typedef struct {
    logic [7:0]  data;
    logic        exp_fv;
    logic [31:0] exp_fd;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One byte offered for one cycle; returns #1 after the capturing edge.
  task automatic send(input logic [7:0] b, input logic last);
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'h11, 1'b0, 32'h0,        16'd0};
    vecs[1]  = '{8'h22, 1'b0, 32'h0,        16'd0};
    vecs[2]  = '{8'h33, 1'b0, 32'h0,        16'd0};
    vecs[3]  = '{8'h44, 1'b1, 32'h44332211, 16'd1};
    vecs[4]  = '{8'h55, 1'b0, 32'h0,        16'd1};
    vecs[5]  = '{8'h66, 1'b0, 32'h0,        16'd1};
    vecs[6]  = '{8'h77, 1'b0, 32'h0,        16'd1};
    vecs[7]  = '{8'h88, 1'b1, 32'h88776655, 16'd2};
    vecs[8]  = '{8'h99, 1'b0, 32'h0,        16'd2};
    vecs[9]  = '{8'hAA, 1'b0, 32'h0,        16'd2};
    vecs[10] = '{8'hBB, 1'b0, 32'h0,        16'd2};
    vecs[11] = '{8'hCC, 1'b1, 32'hCCBBAA99, 16'd3};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; frame_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst frame_valid", 32'(frame_valid), 32'd0);
    check("rst frame_data", frame_data, 32'h0);
    check("rst frame_count", 32'(frame_count), 32'd0);
`ifdef SORT_PACK_LAST_EN
    check("rst frame_len", 32'(frame_len), 32'd0);
`endif
    rst = 1'b0;
    idle();

    // Streaming with frame_ready held high
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].data, 1'b0);
      check($sformatf("stream[%0d] fv", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
      if (vecs[i].exp_fv) check($sformatf("stream[%0d] fd", i), frame_data, vecs[i].exp_fd);
      check($sformatf("stream[%0d] cnt", i), 32'(frame_count), 32'(vecs[i].exp_cnt));
      check($sformatf("stream[%0d] in_ready", i), 32'(in_ready), 32'd1);
    end
    idle();
    check("stream drain fv", 32'(frame_valid), 32'd0);

    // Backpressure: first frame held, second assembled, intake stalls
    frame_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
      if (i >= 4) begin
        check($sformatf("bp hold fv %0d", i), 32'(frame_valid), 32'd1);
        check($sformatf("bp hold fd %0d", i), frame_data, 32'h04030201);
      end
    end
    check("bp in_ready low", 32'(in_ready), 32'd0);
    check("bp cnt", 32'(frame_count), 32'd4);
    send(8'hEE, 1'b0);
    check("bp still low", 32'(in_ready), 32'd0);
    check("bp still held", frame_data, 32'h04030201);
    frame_ready = 1'b1;
    idle();
    check("bp release fv", 32'(frame_valid), 32'd1);
    check("bp release fd", frame_data, 32'h08070605);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release cnt", 32'(frame_count), 32'd5);
    idle();
    check("bp drained fv", 32'(frame_valid), 32'd0);

    // 4th byte accepted in the same cycle the held frame is taken
    frame_ready = 1'b0;
    send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b0); send(8'h24, 1'b0);
    check("swap first fd", frame_data, 32'h24232221);
    send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0);
    frame_ready = 1'b1;
    send(8'h34, 1'b0);
    check("swap no bubble fv", 32'(frame_valid), 32'd1);
    check("swap fd", frame_data, 32'h34333231);
    check("swap cnt", 32'(frame_count), 32'd7);

    // Reset mid-frame
    send(8'hE1, 1'b0); send(8'hE2, 1'b0);
    rst = 1'b1;
    #1;
    check("mid rst fv", 32'(frame_valid), 32'd0);
    check("mid rst fd", frame_data, 32'h0);
    check("mid rst cnt", 32'(frame_count), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    idle();
    rst = 1'b0;
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    check("post rst fv", 32'(frame_valid), 32'd1);
    check("post rst fd", frame_data, 32'hDDCCBBAA);
    check("post rst cnt", 32'(frame_count), 32'd1);

`ifdef SORT_PACK_LAST_EN
    send(8'h05, 1'b0); send(8'h06, 1'b1);
    check("last fv", 32'(frame_valid), 32'd1);
    check("last fd", frame_data, 32'hFFFF0605);
    check("last len", 32'(frame_len), 32'd2);
    send(8'h07, 1'b1);
    check("last1 fd", frame_data, 32'hFFFFFF07);
    check("last1 len", 32'(frame_len), 32'd1);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
    check("last4 fd", frame_data, 32'h04030201);
    check("last4 len", 32'(frame_len), 32'd4);
`endif

    // Counter wrap from a preloaded all-ones value
    idle();
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count_q;
    idle();
    check("wrap preload", 32'(frame_count), 32'h0000FFFF);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    check("wrap cnt", 32'(frame_count), 32'd0);
    check("wrap fd", frame_data, 32'h04030201);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sort_4x8b_frame_packer.md
# sort_4x8b_frame_packer

Upstream feeder for the 4×8-bit bubble sorter. It accepts an 8-bit byte stream under a valid/ready handshake and assembles every four bytes into a 32-bit frame. It registers that frame and presents it, with its own valid/ready handshake, on the bus that drives the sorter's `data_in`. A one-frame assembly stage plus a one-frame output holding stage let byte intake continue while a finished frame waits for the consumer.

## Interface
- `LANES`, default 4: bytes per frame.
- `W`, default 8: bits per byte.
- `PAD`, default 8'h00: fill value for short frames (only meaningful with `SORT_PACK_LAST_EN`).
- `clk`  input  1: sole clock, rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `in_data`  input  W: incoming byte.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: packer accepts a byte this cycle.
- `in_last`  input  1: last byte of a short frame (present only with `SORT_PACK_LAST_EN`).
- `frame_data`  output  LANES*W: assembled frame; lane 0 (first byte received) in [7:0], lane 3 in [31:24].
- `frame_valid`  output  1: `frame_data` holds a complete frame.
- `frame_ready`  input  1: consumer takes the frame.
- `frame_len`  output  3: valid lanes, 1..4 (present only with `SORT_PACK_LAST_EN`).
- `frame_count`  output  16: count of frames delivered; wraps from 16'hFFFF to 0.

## Operation
- Byte accepted (in_fire) = `in_valid & in_ready`. Frame delivered (out_fire) = `frame_valid & frame_ready`.
- Assembly stage:
  - Lane index `idx`, 0..LANES-1.
  - Fill counter `cnt`, 0..LANES.
  - On in_fire, the byte is written to lane `idx` and `idx` increments.
- Assembly is complete when `cnt == LANES`.
- Output stage is free when `!frame_valid | frame_ready`.
- Transfer:
  - Happens when assembly is complete (or completes on this in_fire) and the output stage is free.
  - The frame moves to the `frame_data` register and `frame_valid` is 1 next cycle.
  - `cnt`/`idx` return to 0 and `frame_count` increments in the same cycle as the transfer.
- Stall: if assembly is complete and the output stage is not free, the assembly holds its frame, `in_ready = 0`, and `idx`/`cnt` are frozen.
- `in_ready = (cnt != LANES)`. It is a registered-state function only; it does not depend on `frame_ready` combinationally.
- Simultaneous 4th-byte in_fire and out_fire: the new frame replaces the delivered one with no bubble; `frame_valid` stays 1.
- `frame_data`/`frame_valid` are stable while `frame_valid & !frame_ready` (AXI-style hold).
- `frame_count` is 16 bits and wraps modulo 2^16 without any flag.
- Reset mid-frame: the partial assembly is discarded and the held frame is dropped.

## Timing
- Reset values:
  - `in_ready = 1`
  - `frame_valid = 0`
  - `frame_data = 0`
  - `frame_count = 0`
  - `frame_len = 0`
  - `idx`/`cnt` = 0
- Latency: 1 cycle from the in_fire of the 4th byte to `frame_valid` high.
- Throughput: one byte per cycle, sustained, when `frame_ready` is held 1 (one frame every 4 cycles).
- Backpressure:
  - With output held and assembly full, `in_ready` is 0 from the cycle after the 4th byte.
  - `in_ready` returns to 1 the cycle after the out_fire that frees the output stage.
- No combinational path from inputs to outputs.

## Configuration
- `SORT_PACK_LAST_EN` defined:
  - `in_last` and `frame_len` ports exist.
  - An in_fire with `in_last = 1` completes the frame immediately.
  - Lanes `idx+1..LANES-1` are filled with `PAD` and `frame_len = idx+1`.
  - `in_last` on lane 3 behaves as a normal full frame with `frame_len = 4`.
- Not defined: the ports are absent; frames are always exactly LANES bytes.

## Structure
- Shared package `sort_pkg`: `LANES`, `W`, `FRAME_W = LANES*W`, `typedef logic [W-1:0] lane_t`, `typedef lane_t [LANES-1:0] frame_t`, and the `frame_count` width constant.
- Single module. No sub-module is required.
- The output register is a plain valid/data holding register coded inline; it is not split out.

## Test plan
- Reset, then bytes 11,22,33,44 on consecutive cycles with `frame_ready = 1` → `frame_data = 32'h44332211` and `frame_valid` high one cycle after the 4th byte; `frame_count = 1`.
- Streaming 12 bytes with `frame_ready = 1` → three frames on cycles 5, 9 and 13; `in_ready` never drops.
- `frame_ready = 0`, 8 bytes offered → first frame held stable, second frame assembled, `in_ready = 0` after the 8th byte; raise `frame_ready` → the second frame appears the next cycle and `in_ready` returns to 1.
- `rst` asserted after 2 bytes → all outputs zero; the next 4 bytes AA,BB,CC,DD yield `32'hDDCCBBAA`.
- `SORT_PACK_LAST_EN`, `PAD = 8'hFF`, bytes 05,06 with `in_last` on 06 → `frame_data = 32'hFFFF0605`, `frame_len = 2`.
- Preload `frame_count` to 16'hFFFF via 65535 frames (or a forced value), deliver one more frame → `frame_count = 0`.
